// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequential scanner that drives the select of a downstream
// 16:1 bit mux, waits SETTLE_CYCLES on each enabled channel, samples the
// returned bit and publishes a 16-bit snapshot with a one-cycle valid pulse.
//
// Optional feature macro: MUX_SCAN_CHANGE_DET_EN
//   defined   : change pulses with valid when the new snapshot differs from
//               the previously published one (prev_q register).
//   undefined : change is tied to 0.
//
// Ports:
//   clk        in  1   rising-edge clock
//   rst        in  1   synchronous active-high reset
//   start      in  1   begin a scan when idle (ignored while busy)
//   continuous in  1   auto-restart a scan at completion
//   ch_mask    in  16  per-channel enable, latched at scan start
//   mux_out    in  1   bit returned by the downstream mux
//   sel        out 4   channel select to the mux
//   data       out 16  last completed snapshot (bit i = channel i)
//   valid      out 1   one-cycle pulse when data updates
//   busy       out 1   scan in progress
//   change     out 1   one-cycle pulse with valid when data changed
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic [15:0] ch_mask,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic [15:0] data,
    output logic        valid,
    output logic        busy,
    output logic        change
);

    localparam int unsigned N_CH  = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        SKIP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_CH-1:0]   shadow_q, shadow_d;
    logic              advance_c;
    logic              start_scan_c;
    logic [IDX_W-1:0]  idx_inc_c;
    logic              busy_d;

    // Next-state logic: channel walk, settle counting and bit capture.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        shadow_d     = shadow_q;
        advance_c    = 1'b0;
        start_scan_c = 1'b0;
        idx_inc_c    = idx_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    start_scan_c = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                shadow_d[idx_q] = mux_out;
                advance_c       = 1'b1;
            end
            SKIP: begin
                advance_c = 1'b1;
            end
            DONE: begin
                if (continuous || start) begin
                    start_scan_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Move to the next channel, or finish after channel 15 (no wrap).
        if (advance_c) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_inc_c;
                state_d = mask_q[idx_inc_c] ? SETTLE : SKIP;
            end
        end

        // A new scan relatches the mask and clears the partial snapshot.
        if (start_scan_c) begin
            mask_d   = ch_mask;
            idx_d    = '0;
            cnt_d    = '0;
            shadow_d = '0;
            state_d  = ch_mask[0] ? SETTLE : SKIP;
        end
    end

    assign busy_d = (state_d == SETTLE) || (state_d == SAMPLE) || (state_d == SKIP);

    // State and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            sel      <= '0;
            data     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sel      <= busy_d ? idx_d : '0;
            busy     <= busy_d;
            valid    <= (state_d == DONE);
            if (state_d == DONE) begin
                data <= shadow_d;
            end
        end
    end

`ifdef MUX_SCAN_CHANGE_DET_EN
    logic [N_CH-1:0] prev_q;

    // Change detection against the previously published snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            change <= 1'b0;
        end else begin
            change <= (state_d == DONE) && (shadow_d != prev_q);
            if (state_d == DONE) begin
                prev_q <= shadow_d;
            end
        end
    end
`else
    assign change = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a 16:1 mux model feeds mux_out,
// and each scan is predicted from the mask and mux inputs (sel trace,
// snapshot = in & mask, change vs. last published snapshot).
module tb_mux_scan_ctrl;

    localparam int unsigned S = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [15:0] ch_mask;
    logic        mux_out;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic        change;

    logic [15:0] mux_in;
    logic [15:0] prev_data;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_valid_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 16:1 mux model
    assign mux_out = mux_in[sel];

    mux_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .mux_out    (mux_out),
        .sel        (sel),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .change     (change)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pulse start with the given mask/input; returns at the first busy cycle.
    task automatic do_start(input logic [15:0] mask, input logic [15:0] in_val);
        ch_mask = mask;
        mux_in  = in_val;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Follow one scan from its first busy cycle through its DONE cycle.
    task automatic check_scan(input logic [15:0] mask, input logic [15:0] in_val,
                              input bit disturb, input bit drop_cont);
        int          ch_list[$];
        logic [15:0] exp_data;
        logic        exp_change;
        for (int c = 0; c < 16; c++) begin
            if (mask[c]) begin
                for (int r = 0; r <= int'(S); r++) ch_list.push_back(c);
            end else begin
                ch_list.push_back(c);
            end
        end
        foreach (ch_list[i]) begin
            check_eq("busy", 32'(busy), 1);
            check_eq("sel", 32'(sel), ch_list[i]);
            check_eq("valid_early", 32'(valid), 0);
            if (disturb && i == 2) begin
                start   = 1'b1;
                ch_mask = ~mask;
            end
            if (disturb && i == 3) start = 1'b0;
            if (drop_cont && i == 0) continuous = 1'b0;
            @(negedge clk);
        end
        exp_data = mask & in_val;
`ifdef MUX_SCAN_CHANGE_DET_EN
        exp_change = (exp_data != prev_data);
`else
        exp_change = 1'b0;
`endif
        check_eq("valid", 32'(valid), 1);
        check_eq("done_busy", 32'(busy), 0);
        check_eq("done_sel", 32'(sel), 0);
        check_eq("data", 32'(data), 32'(exp_data));
        check_eq("change", 32'(change), 32'(exp_change));
        prev_data      = exp_data;
        last_valid_cyc = cyc;
    endtask

    task automatic check_idle();
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_valid", 32'(valid), 0);
        check_eq("idle_change", 32'(change), 0);
        check_eq("idle_sel", 32'(sel), 0);
    endtask

    initial begin
        int          t1;
        int          vcount;
        logic [15:0] m;
        logic [15:0] v;

        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        ch_mask    = '0;
        mux_in     = '0;
        prev_data  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_sel", 32'(sel), 0);
        check_eq("rst_data", 32'(data), 0);
        check_eq("rst_valid", 32'(valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_change", 32'(change), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full mask
        do_start(16'hFFFF, 16'hA5C3);
        check_scan(16'hFFFF, 16'hA5C3, 1'b0, 1'b0);
        check_idle();

        // Half mask
        do_start(16'h00FF, 16'hFFFF);
        check_scan(16'h00FF, 16'hFFFF, 1'b0, 1'b0);
        check_idle();

        // All-zero mask
        do_start(16'h0000, 16'hFFFF);
        check_scan(16'h0000, 16'hFFFF, 1'b0, 1'b0);
        check_idle();

        // Continuous back-to-back scans
        continuous = 1'b1;
        do_start(16'hFFFF, 16'h0001);
        check_scan(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        t1     = last_valid_cyc;
        mux_in = 16'h8000;
        @(negedge clk);
        check_scan(16'hFFFF, 16'h8000, 1'b0, 1'b0);
        check_eq("valid_spacing", last_valid_cyc - t1, 33);
        @(negedge clk);
        check_scan(16'hFFFF, 16'h8000, 1'b0, 1'b1);
        check_idle();

        // start re-pulsed and mask toggled mid-scan
        v = 16'($urandom);
        do_start(16'h0F0F, v);
        check_scan(16'h0F0F, v, 1'b1, 1'b0);
        ch_mask = 16'h0F0F;
        check_idle();

        // Reset mid-scan
        do_start(16'hFFFF, 16'($urandom));
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_busy", 32'(busy), 0);
        check_eq("mrst_sel", 32'(sel), 0);
        check_eq("mrst_data", 32'(data), 0);
        check_eq("mrst_valid", 32'(valid), 0);
        rst       = 1'b0;
        prev_data = '0;
        vcount    = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check_eq("mrst_no_valid", vcount, 0);
        v = 16'($urandom);
        do_start(16'hFFFF, v);
        check_scan(16'hFFFF, v, 1'b0, 1'b0);
        check_idle();

        // Randomized scans
        for (int n = 0; n < 8; n++) begin
            m = 16'($urandom);
            v = 16'($urandom);
            do_start(m, v);
            check_scan(m, v, 1'b0, 1'b0);
            check_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential channel scanner that sits directly upstream of the 16:1 bit multiplexer and drives its 4-bit select. It steps `sel` through channels 0..15, waits for the mux output to settle, and samples the returned bit. It assembles the bits into a 16-bit snapshot and publishes the snapshot with a one-cycle valid pulse. Typical use is polling 16 status lines through a single mux output.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles `sel` is held on an enabled channel before sampling. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a scan when idle; ignored while busy.
- `continuous` in 1: when 1 at scan completion, the next scan starts automatically.
- `ch_mask` in 16: per-channel enable (1 = scan); latched at scan start.
- `mux_out` in 1: bit returned by the downstream mux.
- `sel` out 4: channel select to the mux.
- `data` out 16: last completed snapshot; bit i = channel i.
- `valid` out 1: one-cycle pulse when `data` updates.
- `busy` out 1: scan in progress.
- `change` out 1: one-cycle pulse with `valid` when the new `data` differs from the previous value (see Configuration).

## Operation
- FSM states:
  - IDLE: `sel`=0, `busy`=0.
  - SETTLE: `sel`=idx; counts `SETTLE_CYCLES`.
  - SAMPLE: `sel`=idx; captures `mux_out` into shadow[idx].
  - SKIP: masked channel.
  - DONE: publish.
- IDLE→SETTLE or SKIP on `start`=1: latches `ch_mask` into `mask_q`, sets idx=0, clears shadow.
- Per channel:
  - `mask_q[idx]`=1: SETTLE for `SETTLE_CYCLES` cycles, then SAMPLE for 1 cycle.
  - `mask_q[idx]`=0: SKIP for 1 cycle; shadow[idx] stays 0.
- After SAMPLE or SKIP: idx<15 → idx+1 and next channel; idx=15 → DONE. No wrap to idx 0 inside a scan.
- DONE (one cycle):
  - `data`←shadow, `valid`=1, `busy`=0, `sel`=0.
  - Next state is a new scan if `continuous`=1 or `start`=1, else IDLE.
  - A new scan started from DONE relatches `ch_mask`.
- `start` while busy: ignored, no queuing.
- `ch_mask` changes mid-scan: no effect until the next scan.
- All-zero mask: 16 SKIP cycles, then DONE with `data`=0.
- Reset values: `sel`=0, `data`=0, `valid`=0, `busy`=0, `change`=0, state IDLE, shadow=0, idx=0.
- Reset mid-scan: the scan is abandoned, the partial shadow is discarded, and no `valid` pulse is produced.

## Timing
- `start` sampled at edge k → from cycle k+1: `busy`=1, `sel`=0.
- Enabled channel: `sel` stable for `SETTLE_CYCLES`+1 cycles; `mux_out` sampled at the end of the last one.
- Scan length (busy cycles) = 16 + E×`SETTLE_CYCLES`, where E = number of enabled channels.
  - Full mask, `SETTLE_CYCLES`=1: 32 busy cycles; `valid` in the 33rd cycle after the `start` edge.
- `valid`, `change`, `data` update: registered, same cycle (DONE).
- `continuous`=1: back-to-back scans with exactly one DONE cycle (`busy`=0) between them.
- `sel` changes only on clock edges; it is glitch-free from this block's side.

## Configuration
- Macro `MUX_SCAN_CHANGE_DET_EN`.
- Defined:
  - A 16-bit `prev_q` register holds the last published `data`.
  - `change`=1 in DONE iff shadow≠`prev_q`; `prev_q` updates in DONE.
  - `prev_q` resets to 0, so the first scan with any bit set pulses `change`.
- Undefined: `change` is tied to 0 and no `prev_q` register exists. All other behaviour is identical.

## Test plan
- Reset, `mux_out` driven from a 16:1 mux model with in=16'hA5C3, full mask, `SETTLE_CYCLES`=1, `start` pulse:
  - `sel` steps 0..15, each held 2 cycles.
  - `valid` in cycle 33 with `data`=16'hA5C3; `busy` high for cycles 1..32.
- `ch_mask`=16'h00FF, in=16'hFFFF:
  - 24 busy cycles; `data`=16'h00FF.
  - `sel` visits 8..15 for 1 cycle each.
- `ch_mask`=0:
  - 16 busy cycles; `data`=0; `valid` pulses.
  - `change`=1 if the previous `data` was nonzero (macro defined).
- `continuous`=1, in changes from 16'h0001 to 16'h8000 between scans:
  - Consecutive `valid` pulses are spaced 33 cycles apart.
  - Second scan gives `data`=16'h8000 with `change`=1.
  - A third identical scan gives `change`=0.
- `rst` asserted in cycle 10 of a scan:
  - Next cycle: `busy`=0, `sel`=0, `data` unchanged from reset value 0.
  - No `valid` pulse; a new `start` produces a correct full scan.
- `start` re-pulsed mid-scan and `ch_mask` toggled mid-scan:
  - Neither affects the current scan.
  - Timing and result match the mask latched at the original `start`.
